// File: rtl/fc_classifier_if.sv
// ============================================================================
// Module      : fc_classifier_if
// Description : Frame, weight-ROM and result bundle for the FC classifier.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fc_classifier_if #(
    parameter int N_IN  = 27,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int ACC_W = 24,
    parameter int AW    = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN*DW-1:0]   pool_lin;
    logic [AW-1:0]        w_addr;
    logic [WW-1:0]        w_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           class_idx;
    logic [ACC_W-1:0]     class_score;

    modport slave (
        input  in_valid, pool_lin, w_data, out_ready,
        output in_ready, w_addr, out_valid, class_idx, class_score
    );

    modport master (
        output in_valid, pool_lin, w_data, out_ready,
        input  in_ready, w_addr, out_valid, class_idx, class_score
    );
endinterface

`default_nettype wire

// File: rtl/fc_classifier.sv
// ============================================================================
// Module      : fc_classifier
// Description : Sequential fully connected layer with running argmax.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fc_classifier #(
    parameter int N_IN  = 27,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int ACC_W = 24,
    parameter int AW    = 9
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fc_classifier_if.slave   bus
);

    localparam int c_fw = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int c_pw = DW + WW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [N_IN*DW-1:0]      frame_q;
    logic [AW-1:0]           w_addr_q;

    // Address stage: which (class, feature) is on w_addr this cycle.
    logic                    a_vld_q;
    logic [c_fw-1:0]         a_feat_q;
    logic [3:0]              a_cls_q;

    // Data stage: which (class, feature) w_data belongs to this cycle.
    logic                    d_vld_q;
    logic [c_fw-1:0]         d_feat_q;
    logic [3:0]              d_cls_q;
    logic                    d_last_q;
    logic                    d_final_q;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [3:0]              best_idx_q;
    logic signed [ACC_W-1:0] best_score_q;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic [DW-1:0]           w_feat;
    logic signed [DW:0]      w_feat_s;
    logic signed [WW-1:0]    w_wt;
    logic signed [c_pw-1:0]  w_prod;
    logic                    w_a_last;

    always_comb begin
        w_feat   = frame_q[d_feat_q*DW +: DW];
        w_feat_s = {1'b0, w_feat};
        w_wt     = bus.w_data;
        w_prod   = w_feat_s * w_wt;
        acc_d    = acc_q + {{(ACC_W-c_pw){w_prod[c_pw-1]}}, w_prod};
        w_a_last = (a_feat_q == c_fw'(N_IN-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            w_addr_q     <= '0;
            a_vld_q      <= 1'b0;
            a_feat_q     <= '0;
            a_cls_q      <= '0;
            d_vld_q      <= 1'b0;
            d_feat_q     <= '0;
            d_cls_q      <= '0;
            d_last_q     <= 1'b0;
            d_final_q    <= 1'b0;
            acc_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        frame_q    <= bus.pool_lin;
                        w_addr_q   <= '0;
                        a_vld_q    <= 1'b1;
                        a_feat_q   <= '0;
                        a_cls_q    <= '0;
                        d_vld_q    <= 1'b0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end

                S_RUN: begin
                    d_vld_q   <= a_vld_q;
                    d_feat_q  <= a_feat_q;
                    d_cls_q   <= a_cls_q;
                    d_last_q  <= w_a_last;
                    d_final_q <= w_a_last && (a_cls_q == 4'(N_OUT-1));

                    if (a_vld_q) begin
                        if (w_a_last) begin
                            a_feat_q <= '0;
                            if (a_cls_q == 4'(N_OUT-1)) begin
                                a_vld_q <= 1'b0;
                            end else begin
                                a_cls_q <= a_cls_q + 4'd1;
                            end
                        end else begin
                            a_feat_q <= a_feat_q + c_fw'(1);
                        end
                        // The final address stays on the bus once issuing stops.
                        if (!(w_a_last && (a_cls_q == 4'(N_OUT-1)))) begin
                            w_addr_q <= w_addr_q + AW'(1);
                        end
                    end

                    if (d_vld_q) begin
                        if (d_last_q) begin
                            acc_q <= '0;
                            if ((d_cls_q == 4'd0) || (acc_d > best_score_q)) begin
                                best_idx_q   <= d_cls_q;
                                best_score_q <= acc_d;
                            end
                            if (d_final_q) begin
                                d_vld_q     <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end
                        end else begin
                            acc_q <= acc_d;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.class_idx   = best_idx_q;
    assign bus.class_score = best_score_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_classifier.sv
// ============================================================================
// Module      : tb_fc_classifier
// Description : Self-checking bench for fc_classifier against an argmax model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fc_classifier;

    localparam int N_IN  = 27;
    localparam int N_OUT = 10;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int ACC_W = 24;
    localparam int AW    = 9;
    localparam int NW    = N_IN * N_OUT;

    logic clk;
    logic rst_n;

    fc_classifier_if #(.N_IN(N_IN), .DW(DW), .WW(WW), .ACC_W(ACC_W), .AW(AW)) bus ();

    fc_classifier #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .ACC_W(ACC_W), .AW(AW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int feat [N_IN];
    int rom  [NW];

    // Synchronous ROM model: data one cycle after the address.
    always @(posedge clk) begin
        if (int'(bus.w_addr) < NW) bus.w_data <= 8'(rom[int'(bus.w_addr)]);
        else                       bus.w_data <= '0;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(output int idx, output longint score);
        longint s;
        idx   = 0;
        score = 0;
        for (int o = 0; o < N_OUT; o++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++) s += longint'(feat[i]) * longint'(rom[o*N_IN + i]);
            if (o == 0 || s > score) begin
                idx   = o;
                score = s;
            end
        end
    endtask

    task automatic load_pool();
        for (int i = 0; i < N_IN; i++) bus.pool_lin[i*DW +: DW] = 8'(feat[i]);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N_IN; i++) feat[i] = int'($urandom_range(0, 255));
        for (int k = 0; k < NW; k++)   rom[k]  = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic send(input string tag);
        @(negedge clk);
        load_pool();
        check_eq({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.pool_lin = '0;
    endtask

    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.out_valid || cyc >= 400) break;
        end
        check_eq({tag, "_latency"}, longint'(cyc), 271);
    endtask

    task automatic check_result(input string tag, input int eidx, input longint escore);
        check_eq({tag, "_idx"}, longint'(bus.class_idx), longint'(eidx));
        check_eq({tag, "_score"}, longint'($signed(bus.class_score)), escore);
        check_eq({tag, "_busy"}, longint'(bus.in_ready), 0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, "_rdy_after"}, longint'(bus.in_ready), 1);
        check_eq({tag, "_ov_after"}, longint'(bus.out_valid), 0);
    endtask

    task automatic do_frame(input string tag);
        int     eidx;
        longint escore;
        model(eidx, escore);
        send(tag);
        wait_result(tag);
        check_result(tag, eidx, escore);
        release_result(tag);
    endtask

    initial begin
        int     eidx;
        longint escore;
        int     extra_ov;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pool_lin  = '0;
        for (int i = 0; i < N_IN; i++) feat[i] = 0;
        for (int k = 0; k < NW; k++)   rom[k]  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", longint'(bus.in_ready), 1);
        check_eq("rst_out_valid", longint'(bus.out_valid), 0);
        check_eq("rst_idx", longint'(bus.class_idx), 0);
        check_eq("rst_score", longint'(bus.class_score), 0);
        check_eq("rst_waddr", longint'(bus.w_addr), 0);

        // Zero features with random weights: every class ties at 0.
        rand_frame();
        for (int i = 0; i < N_IN; i++) feat[i] = 0;
        do_frame("zero");

        for (int i = 0; i < N_IN; i++) feat[i] = 255;
        for (int k = 0; k < NW; k++)   rom[k]  = (k / N_IN == 3) ? 1 : 0;
        model(eidx, escore);
        check_eq("hot_model", escore, 6885);
        do_frame("hot3");

        for (int k = 0; k < NW; k++) rom[k] = -128;
        do_frame("negext");

        for (int f = 0; f < 4; f++) begin
            rand_frame();
            do_frame($sformatf("rand%0d", f));
        end

        // Backpressure with in_valid/pool_lin toggling in DONE.
        rand_frame();
        model(eidx, escore);
        send("bp");
        wait_result("bp");
        check_eq("bp_waddr_hold", longint'(bus.w_addr), longint'(NW - 1));
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < N_IN; i++) bus.pool_lin[i*DW +: DW] = 8'($urandom_range(0, 255));
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("bp_ov%0d", c), longint'(bus.out_valid), 1);
            check_result($sformatf("bp%0d", c), eidx, escore);
        end
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("bp_rdy_after", longint'(bus.in_ready), 1);
        check_eq("bp_ov_after", longint'(bus.out_valid), 0);

        // Reset in the middle of frame A; outputs must clear before the next edge.
        rand_frame();
        send("frmA");
        repeat (99) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", longint'(bus.in_ready), 1);
        check_eq("mid_rst_out_valid", longint'(bus.out_valid), 0);
        check_eq("mid_rst_idx", longint'(bus.class_idx), 0);
        check_eq("mid_rst_score", longint'(bus.class_score), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N_IN; i++) feat[i] = i;
        for (int k = 0; k < NW; k++)   rom[k]  = k / N_IN;
        model(eidx, escore);
        check_eq("frmB_model", escore, 3159);
        do_frame("frmB");

        extra_ov = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.out_valid) extra_ov++;
        end
        check_eq("single_result", longint'(extra_ov), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
